// File: rtl/aurora_rx_pkg.sv
// Shared definitions for the Aurora RX CRC filter: tuser bit positions,
// the layout of a buffered word and the write-side state encoding.
package aurora_rx_pkg;

    // tuser bits carried on the tlast beat
    localparam int CRC_PASS_BIT  = 0;
    localparam int CRC_VALID_BIT = 1;

    // Buffered word layout: {last, keep[3:0], data[31:0]}
    localparam int WORD_WIDTH = 37;
    localparam int LAST_BIT   = 36;
    localparam int KEEP_LSB   = 32;

    // Write side: accepting a frame, or dropping the rest of an overflowing one
    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wrState_t;

    // A frame is good when CRC passed and, if required, the CRC result was valid
    function automatic logic crcAccept(input logic crcPass,
                                       input logic crcValid,
                                       input logic requireValid);
        return crcPass & (crcValid | ~requireValid);
    endfunction

endpackage

// File: rtl/aurora_rx_buffer_ram.sv
// Simple dual-port frame buffer RAM with a registered read port.
module aurora_rx_buffer_ram
    import aurora_rx_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] rdData
);

    logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

    // Storage write and one-cycle-latency read; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem_r[rdAddr];
        end
    end

endmodule

// File: rtl/aurora_rx_crc_filter.sv
// Store-and-forward CRC filter for the 32-bit Aurora RX stream. Frames are
// written speculatively and only become visible to the read side once their
// tlast beat shows a good CRC; bad and overflowing frames are rolled back.
module aurora_rx_crc_filter
    import aurora_rx_pkg::*;
#(
    parameter int ADDR_WIDTH        = 9,
    parameter bit REQUIRE_CRC_VALID = 1'b1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                 auUserClk,
    input  logic                 resetN,
    input  logic [31:0]          sTdata,
    input  logic [3:0]           sTkeep,
    input  logic [7:0]           sTuser,
    input  logic                 sTlast,
    input  logic                 sTvalid,
    output logic [31:0]          mTdata,
    output logic [3:0]           mTkeep,
    output logic                 mTlast,
    output logic                 mTvalid,
    input  logic                 mTready,
    output logic [CNT_WIDTH-1:0] goodCount,
    output logic [CNT_WIDTH-1:0] crcErrCount,
    output logic [CNT_WIDTH-1:0] overflowCount,
    output logic                 dropPulse
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ---------------- write side ----------------
    wrState_t              wrState_r;
    wrState_t              wrStateNext_s;
    logic [ADDR_WIDTH-1:0] wrPtr_r;
    logic [ADDR_WIDTH-1:0] wrPtrNext_s;
    logic [ADDR_WIDTH-1:0] wrPtrInc_s;
    logic [ADDR_WIDTH-1:0] cmtPtr_r;
    logic [ADDR_WIDTH-1:0] cmtPtrNext_s;
    logic [ADDR_WIDTH-1:0] rdPtr_r;
    logic                  full_s;
    logic                  framePass_s;
    logic                  ramWrEn_s;
    logic                  goodInc_s;
    logic                  crcErrInc_s;
    logic                  ovfInc_s;
    logic [CNT_WIDTH-1:0]  goodCount_r;
    logic [CNT_WIDTH-1:0]  crcErrCount_r;
    logic [CNT_WIDTH-1:0]  overflowCount_r;
    logic                  dropPulse_r;
    logic [WORD_WIDTH-1:0] ramWrData_s;
    logic                  unusedTuser_s;

    assign wrPtrInc_s    = wrPtr_r + PTR_ONE;
    assign full_s        = (wrPtrInc_s == rdPtr_r);
    assign framePass_s   = crcAccept(sTuser[CRC_PASS_BIT], sTuser[CRC_VALID_BIT], REQUIRE_CRC_VALID);
    assign ramWrData_s   = {sTlast, sTkeep, sTdata};
    assign unusedTuser_s = ^sTuser[7:2];

    // Write-side next state: speculative write, commit on good tlast, rollback on drop
    always_comb begin
        wrStateNext_s = wrState_r;
        wrPtrNext_s   = wrPtr_r;
        cmtPtrNext_s  = cmtPtr_r;
        ramWrEn_s     = 1'b0;
        goodInc_s     = 1'b0;
        crcErrInc_s   = 1'b0;
        ovfInc_s      = 1'b0;
        case (wrState_r)
            ACCEPT: begin
                if (sTvalid) begin
                    if (full_s) begin
                        if (sTlast) begin
                            // Overflow wins over the CRC result
                            wrPtrNext_s = cmtPtr_r;
                            ovfInc_s    = 1'b1;
                        end else begin
                            wrStateNext_s = DISCARD;
                        end
                    end else begin
                        ramWrEn_s   = 1'b1;
                        wrPtrNext_s = wrPtrInc_s;
                        if (sTlast) begin
                            if (framePass_s) begin
                                cmtPtrNext_s = wrPtrInc_s;
                                goodInc_s    = 1'b1;
                            end else begin
                                wrPtrNext_s = cmtPtr_r;
                                crcErrInc_s = 1'b1;
                            end
                        end else begin
                            cmtPtrNext_s = cmtPtr_r;
                        end
                    end
                end else begin
                    wrPtrNext_s = wrPtr_r;
                end
            end
            DISCARD: begin
                if (sTvalid && sTlast) begin
                    wrPtrNext_s   = cmtPtr_r;
                    ovfInc_s      = 1'b1;
                    wrStateNext_s = ACCEPT;
                end else begin
                    wrStateNext_s = DISCARD;
                end
            end
            default: begin
                wrStateNext_s = ACCEPT;
                wrPtrNext_s   = cmtPtr_r;
            end
        endcase
    end

    // Write-side state, pointers, outcome counters and drop pulse
    always_ff @(posedge auUserClk or negedge resetN) begin
        if (!resetN) begin
            wrState_r       <= ACCEPT;
            wrPtr_r         <= {ADDR_WIDTH{1'b0}};
            cmtPtr_r        <= {ADDR_WIDTH{1'b0}};
            goodCount_r     <= {CNT_WIDTH{1'b0}};
            crcErrCount_r   <= {CNT_WIDTH{1'b0}};
            overflowCount_r <= {CNT_WIDTH{1'b0}};
            dropPulse_r     <= 1'b0;
        end else begin
            wrState_r   <= wrStateNext_s;
            wrPtr_r     <= wrPtrNext_s;
            cmtPtr_r    <= cmtPtrNext_s;
            dropPulse_r <= crcErrInc_s | ovfInc_s;
            if (goodInc_s) begin
                goodCount_r <= goodCount_r + CNT_ONE;
            end
            if (crcErrInc_s) begin
                crcErrCount_r <= crcErrCount_r + CNT_ONE;
            end
            if (ovfInc_s) begin
                overflowCount_r <= overflowCount_r + CNT_ONE;
            end
        end
    end

    // ---------------- read side ----------------
    logic [WORD_WIDTH-1:0] ramRdData_s;
    logic                  dataAvail_s;
    logic                  pop_s;
    logic [1:0]            occ_s;
    logic                  rdIssue_s;
    logic                  rdPending_r;
    logic                  outValid_r;
    logic                  outValidNext_s;
    logic [WORD_WIDTH-1:0] outWord_r;
    logic [WORD_WIDTH-1:0] outWordNext_s;
    logic                  skidValid_r;
    logic                  skidValidNext_s;
    logic [WORD_WIDTH-1:0] skidWord_r;
    logic [WORD_WIDTH-1:0] skidWordNext_s;

    aurora_rx_buffer_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (WORD_WIDTH)
    ) u_ram (
        .clk    (auUserClk),
        .wrEn   (ramWrEn_s),
        .wrAddr (wrPtr_r),
        .wrData (ramWrData_s),
        .rdEn   (rdIssue_s),
        .rdAddr (rdPtr_r),
        .rdData (ramRdData_s)
    );

    // Only committed words are readable; a read is issued only when its result
    // is guaranteed a slot in the output register or skid next cycle
    assign dataAvail_s = (rdPtr_r != cmtPtr_r);
    assign pop_s       = outValid_r & mTready;
    assign occ_s       = {1'b0, outValid_r} + {1'b0, skidValid_r} + {1'b0, rdPending_r};
    assign rdIssue_s   = dataAvail_s && ((occ_s - {1'b0, pop_s}) < 2'd2);

    // Output register plus skid: refill from skid first, then from the RAM result
    always_comb begin
        outValidNext_s  = outValid_r;
        outWordNext_s   = outWord_r;
        skidValidNext_s = skidValid_r;
        skidWordNext_s  = skidWord_r;
        if (!outValid_r || pop_s) begin
            if (skidValid_r) begin
                outValidNext_s  = 1'b1;
                outWordNext_s   = skidWord_r;
                skidValidNext_s = rdPending_r;
                skidWordNext_s  = ramRdData_s;
            end else if (rdPending_r) begin
                outValidNext_s  = 1'b1;
                outWordNext_s   = ramRdData_s;
                skidValidNext_s = 1'b0;
            end else begin
                outValidNext_s  = 1'b0;
                skidValidNext_s = 1'b0;
            end
        end else begin
            if (rdPending_r) begin
                skidValidNext_s = 1'b1;
                skidWordNext_s  = ramRdData_s;
            end else begin
                skidValidNext_s = skidValid_r;
            end
        end
    end

    // Read pointer, in-flight read flag and output/skid registers
    always_ff @(posedge auUserClk or negedge resetN) begin
        if (!resetN) begin
            rdPtr_r     <= {ADDR_WIDTH{1'b0}};
            rdPending_r <= 1'b0;
            outValid_r  <= 1'b0;
            outWord_r   <= {WORD_WIDTH{1'b0}};
            skidValid_r <= 1'b0;
            skidWord_r  <= {WORD_WIDTH{1'b0}};
        end else begin
            rdPending_r <= rdIssue_s;
            if (rdIssue_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
            outValid_r  <= outValidNext_s;
            outWord_r   <= outWordNext_s;
            skidValid_r <= skidValidNext_s;
            skidWord_r  <= skidWordNext_s;
        end
    end

    assign mTvalid       = outValid_r;
    assign mTdata        = outWord_r[31:0];
    assign mTkeep        = outWord_r[KEEP_LSB +: 4];
    assign mTlast        = outWord_r[LAST_BIT];
    assign goodCount     = goodCount_r;
    assign crcErrCount   = crcErrCount_r;
    assign overflowCount = overflowCount_r;
    assign dropPulse     = dropPulse_r;

endmodule

// File: tb/tb_aurora_rx_crc_filter.sv
// Directed bench for aurora_rx_crc_filter. Three instances share the input
// bus: u0 default parameters, u1 with REQUIRE_CRC_VALID=0, u2 with a 16-word
// buffer. Each has its own sTvalid and mTready.
module tb_aurora_rx_crc_filter;

    logic        auUserClk = 1'b0;
    logic        resetN;
    logic [31:0] sTdata;
    logic [3:0]  sTkeep;
    logic [7:0]  sTuser;
    logic        sTlast;
    logic [2:0]  sTvalid;
    logic [2:0]  mTready;

    logic [31:0] mTdata        [3];
    logic [3:0]  mTkeep        [3];
    logic        mTlast        [3];
    logic        mTvalid       [3];
    logic [15:0] goodCount     [3];
    logic [15:0] crcErrCount   [3];
    logic [15:0] overflowCount [3];
    logic        dropPulse     [3];

    logic [36:0] gotQ [3][$];
    logic [36:0] expQ [3][$];
    int          dropSeen [3];

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    logic        prevStall0 = 1'b0;
    logic [36:0] prevWord0  = 37'd0;

    always #5 auUserClk = ~auUserClk;

    aurora_rx_crc_filter #(.ADDR_WIDTH(9), .REQUIRE_CRC_VALID(1'b1), .CNT_WIDTH(16)) u0 (
        .auUserClk(auUserClk), .resetN(resetN), .sTdata(sTdata), .sTkeep(sTkeep),
        .sTuser(sTuser), .sTlast(sTlast), .sTvalid(sTvalid[0]),
        .mTdata(mTdata[0]), .mTkeep(mTkeep[0]), .mTlast(mTlast[0]), .mTvalid(mTvalid[0]),
        .mTready(mTready[0]), .goodCount(goodCount[0]), .crcErrCount(crcErrCount[0]),
        .overflowCount(overflowCount[0]), .dropPulse(dropPulse[0]));

    aurora_rx_crc_filter #(.ADDR_WIDTH(9), .REQUIRE_CRC_VALID(1'b0), .CNT_WIDTH(16)) u1 (
        .auUserClk(auUserClk), .resetN(resetN), .sTdata(sTdata), .sTkeep(sTkeep),
        .sTuser(sTuser), .sTlast(sTlast), .sTvalid(sTvalid[1]),
        .mTdata(mTdata[1]), .mTkeep(mTkeep[1]), .mTlast(mTlast[1]), .mTvalid(mTvalid[1]),
        .mTready(mTready[1]), .goodCount(goodCount[1]), .crcErrCount(crcErrCount[1]),
        .overflowCount(overflowCount[1]), .dropPulse(dropPulse[1]));

    aurora_rx_crc_filter #(.ADDR_WIDTH(4), .REQUIRE_CRC_VALID(1'b1), .CNT_WIDTH(16)) u2 (
        .auUserClk(auUserClk), .resetN(resetN), .sTdata(sTdata), .sTkeep(sTkeep),
        .sTuser(sTuser), .sTlast(sTlast), .sTvalid(sTvalid[2]),
        .mTdata(mTdata[2]), .mTkeep(mTkeep[2]), .mTlast(mTlast[2]), .mTvalid(mTvalid[2]),
        .mTready(mTready[2]), .goodCount(goodCount[2]), .crcErrCount(crcErrCount[2]),
        .overflowCount(overflowCount[2]), .dropPulse(dropPulse[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture handshakes on all instances; check u0 holds its beat while stalled
    always @(negedge auUserClk) begin
        for (int d = 0; d < 3; d++) begin
            if (mTvalid[d] && mTready[d]) gotQ[d].push_back({mTlast[d], mTkeep[d], mTdata[d]});
            if (dropPulse[d]) dropSeen[d]++;
        end
        if (!resetN) begin
            prevStall0 = 1'b0;
        end else begin
            if (prevStall0)
                check("stall_hold", {27'd0, mTvalid[0], mTlast[0], mTkeep[0], mTdata[0]},
                      {27'd0, 1'b1, prevWord0});
            prevStall0 = mTvalid[0] && !mTready[0];
            prevWord0  = {mTlast[0], mTkeep[0], mTdata[0]};
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge auUserClk);
        #1;
    endtask

    // Drive one frame; data = base + i*0x11, last beat keep 0x7
    task automatic sendFrame(input int n, input logic [31:0] base, input logic [7:0] user,
                             input logic hasLast, input logic [2:0] vmask, input logic [2:0] pmask);
        logic isLast;
        for (int i = 0; i < n; i++) begin
            @(posedge auUserClk);
            #1;
            isLast  = hasLast && (i == n - 1);
            sTdata  = base + 32'(i) * 32'h0000_0011;
            sTkeep  = isLast ? 4'h7 : 4'hF;
            sTlast  = isLast;
            sTuser  = isLast ? user : 8'h00;
            sTvalid = vmask;
            for (int d = 0; d < 3; d++)
                if (pmask[d]) expQ[d].push_back({isLast, sTkeep, sTdata});
        end
        @(posedge auUserClk);
        #1;
        sTvalid = 3'b000;
        sTlast  = 1'b0;
        sTuser  = 8'h00;
    endtask

    task automatic checkStream(input int d, input string tag);
        check({tag, "_len"}, 64'(gotQ[d].size()), 64'(expQ[d].size()));
        for (int i = 0; i < gotQ[d].size() && i < expQ[d].size(); i++)
            check({tag, "_word"}, {27'd0, gotQ[d][i]}, {27'd0, expQ[d][i]});
        gotQ[d].delete();
        expQ[d].delete();
    endtask

    initial begin
        resetN  = 1'b0;
        sTdata  = 32'd0;
        sTkeep  = 4'd0;
        sTuser  = 8'd0;
        sTlast  = 1'b0;
        sTvalid = 3'b000;
        mTready = 3'b111;
        for (int d = 0; d < 3; d++) dropSeen[d] = 0;
        waitCycles(3);
        check("rst_out", {27'd0, mTvalid[0], mTlast[0], mTkeep[0], mTdata[0]}, 64'd0);
        check("rst_cnt", {15'd0, dropPulse[0], goodCount[0], crcErrCount[0], overflowCount[0]}, 64'd0);
        resetN = 1'b1;
        waitCycles(2);

        // 4-beat good frame, latency 2 cycles after tlast sampling edge
        sendFrame(4, 32'h11, 8'h03, 1'b1, 3'b001, 3'b001);
        check("lat_e0", 64'(mTvalid[0]), 64'd0);
        waitCycles(1);
        check("lat_e1", 64'(mTvalid[0]), 64'd0);
        waitCycles(1);
        check("lat_e2", {31'd0, mTvalid[0], mTdata[0]}, {31'd0, 1'b1, 32'h11});
        waitCycles(10);
        checkStream(0, "t1");
        check("t1_good", 64'(goodCount[0]), 64'd1);

        // CRC-failing frame followed by a good 2-beat frame
        dropSeen[0] = 0;
        sendFrame(3, 32'hA000_0000, 8'h02, 1'b1, 3'b001, 3'b000);
        sendFrame(2, 32'hB000_0000, 8'h03, 1'b1, 3'b001, 3'b001);
        waitCycles(10);
        checkStream(0, "t2");
        check("t2_crcerr", 64'(crcErrCount[0]), 64'd1);
        check("t2_good", 64'(goodCount[0]), 64'd2);
        check("t2_drops", 64'(dropSeen[0]), 64'd1);

        // crcPass without crcValid: dropped when required, accepted otherwise
        dropSeen[0] = 0;
        sendFrame(3, 32'hC000_0000, 8'h01, 1'b1, 3'b011, 3'b010);
        waitCycles(10);
        checkStream(0, "t3_req");
        checkStream(1, "t3_noreq");
        check("t3_crcerr0", 64'(crcErrCount[0]), 64'd2);
        check("t3_drops0", 64'(dropSeen[0]), 64'd1);
        check("t3_good1", 64'(goodCount[1]), 64'd1);
        check("t3_crcerr1", 64'(crcErrCount[1]), 64'd0);

        // Overflow on a 16-word buffer, then recovery
        mTready[2] = 1'b0;
        sendFrame(20, 32'hD000_0000, 8'h03, 1'b1, 3'b100, 3'b000);
        waitCycles(10);
        check("t4_ovf", 64'(overflowCount[2]), 64'd1);
        check("t4_good", 64'(goodCount[2]), 64'd0);
        check("t4_valid", 64'(mTvalid[2]), 64'd0);
        check("t4_drops", 64'(dropSeen[2]), 64'd1);
        sendFrame(5, 32'hE000_0000, 8'h03, 1'b1, 3'b100, 3'b100);
        waitCycles(5);
        mTready[2] = 1'b1;
        waitCycles(10);
        checkStream(2, "t4b");
        check("t4b_good", 64'(goodCount[2]), 64'd1);
        // Exactly-full frame of 15 words still fits
        mTready[2] = 1'b0;
        sendFrame(15, 32'hF000_0000, 8'h03, 1'b1, 3'b100, 3'b100);
        waitCycles(5);
        check("t4c_cnt", {32'd0, goodCount[2], overflowCount[2]}, {32'd0, 16'd2, 16'd1});
        mTready[2] = 1'b1;
        waitCycles(25);
        checkStream(2, "t4c");

        // Back-pressure toggling 1010 while a 10-beat frame drains
        sendFrame(10, 32'h1000_0000, 8'h03, 1'b1, 3'b001, 3'b001);
        for (int i = 0; i < 40; i++) begin
            @(posedge auUserClk);
            #1;
            mTready[0] = (i % 2 == 0);
        end
        mTready[0] = 1'b1;
        waitCycles(5);
        checkStream(0, "t5");
        check("t5_good", 64'(goodCount[0]), 64'd3);

        // Reset mid-frame with a stalled committed frame at the output
        mTready[0] = 1'b0;
        sendFrame(2, 32'h2000_0000, 8'h03, 1'b1, 3'b001, 3'b000);
        waitCycles(5);
        check("t6_pre", {31'd0, mTvalid[0], mTdata[0]}, {31'd0, 1'b1, 32'h2000_0000});
        check("t6_pre_good", 64'(goodCount[0]), 64'd4);
        sendFrame(3, 32'h3000_0000, 8'h03, 1'b0, 3'b001, 3'b000);
        resetN = 1'b0;
        #1;
        check("t6_rst_out", {27'd0, mTvalid[0], mTlast[0], mTkeep[0], mTdata[0]}, 64'd0);
        check("t6_rst_cnt", {15'd0, dropPulse[0], goodCount[0], crcErrCount[0], overflowCount[0]}, 64'd0);
        waitCycles(1);
        resetN     = 1'b1;
        mTready[0] = 1'b1;
        gotQ[0].delete();
        waitCycles(2);
        sendFrame(3, 32'h4000_0000, 8'h03, 1'b1, 3'b001, 3'b001);
        waitCycles(10);
        checkStream(0, "t6");
        check("t6_cnt", {32'd0, goodCount[0], crcErrCount[0]}, {32'd0, 16'd1, 16'd0});

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/aurora_rx_crc_filter.md
Name: aurora_rx_crc_filter

Overview:
Store-and-forward packet filter on the 32-bit Aurora RX AXI stream, directly downstream of the 64-to-32 RX downconverter output of the Aurora link wrapper, in the user-clock domain. Buffers each incoming frame and examines the CRC status carried in tuser on the tlast beat. Forwards only CRC-passing frames to a back-pressurable AXI-stream master. Discards CRC-failing and overflowing frames and counts every outcome.

Parameters:
ADDR_WIDTH, 9, buffer depth = 2**ADDR_WIDTH words; usable capacity is DEPTH-1 words.
REQUIRE_CRC_VALID, 1, when 1 a frame whose tlast beat has crcValid=0 counts as a CRC failure; when 0 such a frame is accepted.
CNT_WIDTH, 16, width of the outcome counters.

Ports:
auUserClk  in  1  sole clock.
resetN  in  1  asynchronous assert, active-low reset.
sTdata  in  32  RX frame data.
sTkeep  in  4  byte enables.
sTuser  in  8  bit0 crcPass, bit1 crcValid, meaningful only on the tlast beat; bits 7:2 ignored.
sTlast  in  1  end of frame.
sTvalid  in  1  beat valid; no ready, so the input can never be stalled.
mTdata  out  32  forwarded data.
mTkeep  out  4  forwarded byte enables.
mTlast  out  1  forwarded end of frame.
mTvalid  out  1  output beat valid.
mTready  in  1  downstream ready.
goodCount  out  CNT_WIDTH  frames committed.
crcErrCount  out  CNT_WIDTH  frames dropped for CRC.
overflowCount  out  CNT_WIDTH  frames dropped for lack of space.
dropPulse  out  1  one-cycle pulse on any drop.

Behaviour:
- Reset (resetN low, asynchronous): all pointers, counters, mTvalid, mTlast and dropPulse go to 0. mTdata and mTkeep go to 0. Partial frames are discarded; the first beat after deassertion is treated as start of frame.
- Storage: 37-bit words {last, keep, data} in a simple dual-port RAM with 1-cycle read latency.
- Pointers: wrPtr (speculative write), cmtPtr (last committed end), rdPtr. Full condition is wrPtr+1 == rdPtr. All pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- Write side states:
  - ACCEPT: each sTvalid beat is written at wrPtr and wrPtr increments.
  - If the buffer is full on a beat, the beat is not written and the state goes to DISCARD.
  - On the tlast beat, when not full:
    - pass = crcPass & (crcValid | ~REQUIRE_CRC_VALID).
    - If pass: cmtPtr <= wrPtr+1 and goodCount++.
    - Otherwise: wrPtr <= cmtPtr (rollback), crcErrCount++, and dropPulse is asserted.
  - DISCARD: beats are ignored until the tlast beat. On that beat: wrPtr <= cmtPtr, overflowCount++, dropPulse asserted, return to ACCEPT.
  - A tlast beat arriving while full goes straight to the overflow drop in the same cycle. Overflow takes precedence over the CRC result.
- Read side: data is readable when rdPtr != cmtPtr. Only committed words are ever emitted, so partial or failing frames never leak.
- Output stage: registered with a 2-entry skid so RAM latency is hidden. Sustains 1 word/cycle while mTready=1.
- Latency: a tlast-beat commit into an empty buffer gives mTvalid=1 with the first frame word 2 cycles after the edge that sampled that tlast beat.
- AXI rule: once mTvalid is high, mTdata, mTkeep and mTlast hold stable until mTready=1.
- Simultaneous commit and read in the same cycle is legal; rdPtr advances on the pre-commit cmtPtr comparison.
- Counters wrap at 2**CNT_WIDTH.
- A single-beat frame (sTlast on its first beat) is legal.

Decomposition:
- Shared package aurora_rx_pkg holds:
  - tuser bit indices CRC_PASS_BIT=0 and CRC_VALID_BIT=1.
  - Stored word layout offsets (LAST_BIT=36, KEEP_LSB=32).
  - Write state encoding ACCEPT and DISCARD.
- Sub-module aurora_rx_buffer_ram: inferred simple dual-port RAM, 37 bits x 2**ADDR_WIDTH, registered read.

Test Plan:
- 4-beat frame 0x11..0x44 with tuser=0x3 on tlast, mTready=1 -> identical 4 beats out, first mTvalid 2 cycles after tlast, goodCount=1.
- 3-beat frame with tuser=0x2 on tlast, followed by a good 2-beat frame -> only the 2-beat frame is emitted, crcErrCount=1, one dropPulse, goodCount=1.
- REQUIRE_CRC_VALID=1 with tuser=0x1 -> frame dropped and crcErrCount=1. Rerun with REQUIRE_CRC_VALID=0 -> frame forwarded.
- ADDR_WIDTH=4, mTready=0, 20-beat good frame -> nothing emitted, overflowCount=1. A following 5-beat good frame, once mTready=1, is emitted intact.
- mTready toggling 1010 during a 10-beat frame -> every word appears exactly once, in order, held stable while stalled.
- resetN pulsed low mid-frame -> outputs and counters go to 0 immediately. A following good frame passes with correct count and data.
